// File: rtl/color_sample_scheduler_if.sv
// Byte-level command/response path between the sample scheduler (master) and the I2C transaction engine (slave).
interface color_sample_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );
endinterface

// File: rtl/color_sample_scheduler.sv
// Enables the colour sensor once, then every sample period reads its 8 channel bytes and publishes C/R/G/B.
// Publish lands one cycle after the 8th ack; command fields hold while cmd_ready is low, one command outstanding.
module color_sample_scheduler #(
  parameter logic [6:0] I2C_ADDR   = 7'h29,
  parameter logic [7:0] REG_ENABLE = 8'h80,
  parameter logic [7:0] ENABLE_VAL = 8'h03,
  parameter logic [7:0] REG_CDATA  = 8'h94,
  parameter int         PERIOD_W   = 24,
  parameter int         MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  senzor_on,
  input  logic [PERIOD_W-1:0]   sample_period,
  color_sample_scheduler_if.master bus,
  output logic [15:0]           clear,
  output logic [15:0]           red,
  output logic [15:0]           green,
  output logic [15:0]           blue,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, CFG_CMD, CFG_RSP, WAIT, RD_CMD, RD_RSP, PUBLISH, ERROR
  } state_t;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t              state_q, state_d;
  logic [RW-1:0]       retry_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_last;
  logic [2:0]          byte_idx_q;
  logic [63:0]         shadow_q;
  logic [63:0]         pub_q;
  logic                err_q;
  logic                retry_last;
  logic                rsp_ack;
  logic                rsp_nack;

  // A zero period would never match the counter, so it collapses to one WAIT cycle.
  assign cnt_last   = (sample_period == '0) ? '0 : sample_period - 1'b1;
  assign retry_last = (retry_q == RETRY_MAX);
  assign rsp_ack    = bus.rsp_valid & ~bus.rsp_nack;
  assign rsp_nack   = bus.rsp_valid &  bus.rsp_nack;

  assign bus.cmd_dev_addr = I2C_ADDR;
  assign busy       = (state_q != IDLE) && (state_q != ERROR);
  assign err        = err_q;
  assign data_valid = (state_q == PUBLISH);
  // During PUBLISH the freshly completed shadow is shown directly so values and strobe coincide.
  assign {blue, green, red, clear} = (state_q == PUBLISH) ? shadow_q : pub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_reg   = 8'h00;
    bus.cmd_wdata = 8'h00;
    case (state_q)
      IDLE: begin
        if (senzor_on) state_d = CFG_CMD;
      end
      CFG_CMD: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_reg   = REG_ENABLE;
        bus.cmd_wdata = ENABLE_VAL;
        if (bus.cmd_ready)   state_d = CFG_RSP;
        else if (!senzor_on) state_d = IDLE;
      end
      CFG_RSP: begin
        if (bus.rsp_valid) begin
          if (!senzor_on)        state_d = IDLE;
          else if (bus.rsp_nack) state_d = retry_last ? ERROR : CFG_CMD;
          else                   state_d = WAIT;
        end
      end
      WAIT: begin
        if (!senzor_on)             state_d = IDLE;
        else if (cnt_q == cnt_last) state_d = RD_CMD;
      end
      RD_CMD: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = 1'b1;
        bus.cmd_reg   = REG_CDATA + {5'd0, byte_idx_q};
        if (bus.cmd_ready)   state_d = RD_RSP;
        else if (!senzor_on) state_d = IDLE;
      end
      RD_RSP: begin
        if (bus.rsp_valid) begin
          if (!senzor_on)              state_d = IDLE;
          else if (bus.rsp_nack)       state_d = retry_last ? ERROR : RD_CMD;
          else if (byte_idx_q == 3'd7) state_d = PUBLISH;
          else                         state_d = RD_CMD;
        end
      end
      PUBLISH: begin
        state_d = senzor_on ? WAIT : IDLE;
      end
      ERROR: begin
        if (!senzor_on) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q    <= '0;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      pub_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          retry_q <= '0;
          if (senzor_on) err_q <= 1'b0;
        end
        CFG_RSP, RD_RSP: begin
          if (rsp_nack && !retry_last) retry_q <= retry_q + 1'b1;
          if (rsp_ack) begin
            retry_q <= '0;
            cnt_q   <= '0;
            if (state_q == RD_RSP) begin
              shadow_q[{byte_idx_q, 3'b000} +: 8] <= bus.rsp_data;
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == cnt_last) byte_idx_q <= '0;
        end
        PUBLISH: begin
          pub_q <= shadow_q;
          cnt_q <= '0;
        end
        default: ;
      endcase
      if (state_d == ERROR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_color_sample_scheduler.sv
// Bench: behavioural I2C engine plus a command/publish reference built from the sampling rules.
module tb_color_sample_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        senzor_on;
  logic [23:0] sample_period;
  logic [15:0] clear, red, green, blue;
  logic        data_valid, busy, err;

  color_sample_scheduler_if bus();

  color_sample_scheduler dut (
    .clk(clk), .rst_n(rst_n), .senzor_on(senzor_on), .sample_period(sample_period),
    .bus(bus), .clear(clear), .red(red), .green(green), .blue(blue),
    .data_valid(data_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rd_tbl [8];
  int          nack_cnt [256];
  int          nack_plan [256];
  int          stall_left = 0;
  bit          rand_ready = 1'b0;
  int          lat_cfg = 1;
  logic [23:0] cmd_log [$];
  logic [23:0] exp_q [$];
  logic [9:0]  stall_q [$];
  logic [63:0] pub_q [$];
  int          pub_t [$];
  int          cyc = 0;

  bit          pending = 1'b0;
  int          lat_left = 0;
  logic        pend_nack = 1'b0;
  logic [7:0]  pend_data = 8'h00;
  logic [7:0]  eng_off;

  // Engine model: accepts commands, answers after lat cycles, NACKs per-register budgets.
  initial begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    bus.rsp_nack  = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      bus.rsp_data  = 8'h00;
      bus.cmd_ready = 1'b0;
      if (rst_n !== 1'b1) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat_left <= 1) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_nack  = pend_nack;
          bus.rsp_data  = pend_data;
          pending = 1'b0;
        end else begin
          lat_left--;
        end
      end else if (bus.cmd_valid === 1'b1) begin
        if (stall_left > 0 && bus.cmd_rw === 1'b1) begin
          stall_left--;
          stall_q.push_back({bus.cmd_valid, bus.cmd_rw, bus.cmd_reg});
        end else if (rand_ready && $urandom_range(0, 2) == 0) begin
          bus.cmd_ready = 1'b0;
        end else begin
          bus.cmd_ready = 1'b1;
          cmd_log.push_back({bus.cmd_dev_addr, bus.cmd_rw, bus.cmd_reg, bus.cmd_wdata});
          pending  = 1'b1;
          lat_left = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
          pend_nack = (nack_cnt[bus.cmd_reg] > 0);
          if (pend_nack) nack_cnt[bus.cmd_reg]--;
          eng_off   = bus.cmd_reg - 8'h94;
          pend_data = bus.cmd_rw ? rd_tbl[eng_off[2:0]] : 8'h00;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && data_valid === 1'b1) begin
      pub_q.push_back({blue, green, red, clear});
      pub_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int count_reg(input logic [7:0] r);
    int n = 0;
    foreach (cmd_log[i]) if (cmd_log[i][15:8] == r) n++;
    return n;
  endfunction

  function automatic logic [63:0] tbl_word();
    return {rd_tbl[7], rd_tbl[6], rd_tbl[5], rd_tbl[4], rd_tbl[3], rd_tbl[2], rd_tbl[1], rd_tbl[0]};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) nack_plan[i] = 0;
  endtask

  task automatic load_nacks();
    for (int i = 0; i < 256; i++) nack_cnt[i] = nack_plan[i];
  endtask

  // One enable write (plus NACK repeats) then 8 reads per burst; NACKs only hit the first burst.
  task automatic build_exp(input int bursts);
    exp_q.delete();
    for (int k = 0; k <= nack_plan['h80]; k++) exp_q.push_back({7'h29, 1'b0, 8'h80, 8'h03});
    for (int b = 0; b < bursts; b++)
      for (int i = 0; i < 8; i++) begin
        int rep;
        rep = (b == 0) ? nack_plan['h94 + i] : 0;
        for (int k = 0; k <= rep; k++) exp_q.push_back({7'h29, 1'b1, 8'(8'h94 + i), 8'h00});
      end
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_log_len"}, 64'(cmd_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < cmd_log.size() && i < exp_q.size(); i++)
      chk({tag, "_log_entry"}, 64'(cmd_log[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_pub(input int target, input int budget);
    int n = 0;
    while (pub_q.size() < target && n < budget) begin tick(); n++; end
    chk("pub_timeout", 64'(pub_q.size() >= target), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_burst(input string tag);
    int p0;
    logic [63:0] exp_pub;
    cmd_log.delete();
    build_exp(1);
    load_nacks();
    exp_pub = tbl_word();
    p0 = pub_q.size();
    senzor_on = 1'b1;
    wait_pub(p0 + 1, 3000);
    senzor_on = 1'b0;
    wait_idle(200);
    if (pub_q.size() > p0) chk({tag, "_pub"}, pub_q[p0], exp_pub);
    chk({tag, "_pub_count"}, 64'(pub_q.size() - p0), 64'd1);
    compare_log(tag);
  endtask

  initial begin
    int p0, vcnt, pubs, n;
    logic [63:0] a_word;
    rst_n = 1'b0;
    senzor_on = 1'b0;
    sample_period = 24'd10;
    clear_plan();
    load_nacks();
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'h00;
    repeat (3) tick();

    chk("rst_outputs", {blue, green, red, clear}, 64'd0);
    chk("rst_flags", {61'd0, data_valid, busy, err}, 64'd0);
    chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_dev_addr", 64'(bus.cmd_dev_addr), 64'h29);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed burst pair: bytes 01..08, period 10, immediate ready, 1-cycle acks.
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'(i + 1);
    lat_cfg = 1; rand_ready = 1'b0; sample_period = 24'd10;
    clear_plan(); load_nacks(); cmd_log.delete(); build_exp(2);
    p0 = pub_q.size();
    senzor_on = 1'b1;
    wait_pub(p0 + 2, 3000);
    senzor_on = 1'b0;
    wait_idle(200);
    if (pub_q.size() >= p0 + 2) begin
      chk("t2_clear", 64'(pub_q[p0][15:0]), 64'h0201);
      chk("t2_red",   64'(pub_q[p0][31:16]), 64'h0403);
      chk("t2_green", 64'(pub_q[p0][47:32]), 64'h0605);
      chk("t2_blue",  64'(pub_q[p0][63:48]), 64'h0807);
      chk("t2_interval", 64'(pub_t[p0 + 1] - pub_t[p0]), 64'd27);
    end
    compare_log("t2");
    chk("t2_hold_outputs", {blue, green, red, clear}, 64'h0807060504030201);

    // Reset while the byte-4 read is outstanding.
    lat_cfg = 6; cmd_log.delete();
    p0 = pub_q.size();
    senzor_on = 1'b1;
    n = 0;
    while (count_reg(8'h98) < 1 && n < 500) begin tick(); n++; end
    chk("t1_reach_byte4", 64'(count_reg(8'h98)), 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_rst_outputs", {blue, green, red, clear}, 64'd0);
    chk("t1_rst_flags", {61'd0, data_valid, busy, err}, 64'd0);
    senzor_on = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_no_publish", 64'(pub_q.size()), 64'(p0));

    // Five stalled cycles on the first read command.
    lat_cfg = 1; stall_q.delete(); stall_left = 5;
    clear_plan();
    run_burst("t3");
    chk("t3_stall_cycles", 64'(stall_q.size()), 64'd5);
    foreach (stall_q[i]) chk("t3_stall_stable", 64'(stall_q[i]), 64'({1'b1, 1'b1, 8'h94}));
    chk("t3_single_xfer", 64'(count_reg(8'h94)), 64'd1);

    // Byte 3 NACKed twice.
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'($urandom);
    clear_plan(); nack_plan['h97] = 2;
    run_burst("t4");
    chk("t4_reg97_issues", 64'(count_reg(8'h97)), 64'd3);
    chk("t4_err", 64'(err), 64'd0);

    // Config NACKed on every attempt -> ERROR.
    clear_plan(); nack_plan['h80] = 4; load_nacks(); cmd_log.delete();
    senzor_on = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 500) begin tick(); n++; end
    chk("t5_err_set", 64'(err), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (4) exp_q.push_back({7'h29, 1'b0, 8'h80, 8'h03});
    compare_log("t5");
    vcnt = 0;
    repeat (20) begin tick(); if (bus.cmd_valid === 1'b1) vcnt++; end
    chk("t5_no_cmd", 64'(vcnt), 64'd0);
    senzor_on = 1'b0;
    repeat (2) tick();
    chk("t5_err_sticky", 64'(err), 64'd1);
    clear_plan(); cmd_log.delete();
    senzor_on = 1'b1;
    tick();
    chk("t5_err_cleared", 64'(err), 64'd0);
    chk("t5_restart_cmd", 64'({bus.cmd_valid, bus.cmd_rw, bus.cmd_reg}), 64'({1'b1, 1'b0, 8'h80}));
    wait_pub(pub_q.size() + 1, 3000);
    senzor_on = 1'b0;
    wait_idle(200);
    chk("t5_recover_pub", pub_q[pub_q.size() - 1], tbl_word());

    // Abort during the byte-5 read of the second burst: outputs keep the first burst.
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'($urandom);
    a_word = tbl_word();
    lat_cfg = 4; sample_period = 24'd30; clear_plan(); load_nacks(); cmd_log.delete();
    p0 = pub_q.size();
    senzor_on = 1'b1;
    wait_pub(p0 + 1, 3000);
    if (pub_q.size() > p0) chk("t6_first_pub", pub_q[p0], a_word);
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'($urandom);
    rd_tbl[0] = ~a_word[7:0];
    n = 0;
    while (count_reg(8'h99) < 2 && n < 500) begin tick(); n++; end
    chk("t6_reach_byte5", 64'(count_reg(8'h99)), 64'd2);
    tick();
    senzor_on = 1'b0;
    pubs = pub_q.size();
    wait_idle(200);
    chk("t6_no_publish", 64'(pub_q.size()), 64'(pubs));
    chk("t6_outputs_kept", {blue, green, red, clear}, a_word);
    chk("t6_no_byte6", 64'(count_reg(8'h9A)), 64'd1);

    // Zero period behaves as one.
    for (int i = 0; i < 8; i++) rd_tbl[i] = 8'($urandom);
    lat_cfg = 1; sample_period = 24'd0; clear_plan(); load_nacks(); cmd_log.delete(); build_exp(2);
    p0 = pub_q.size();
    senzor_on = 1'b1;
    wait_pub(p0 + 2, 3000);
    senzor_on = 1'b0;
    wait_idle(200);
    if (pub_q.size() >= p0 + 2) chk("t7_interval", 64'(pub_t[p0 + 1] - pub_t[p0]), 64'd18);
    compare_log("t7");

    // Randomized sessions: data, NACK plans, ready gaps, latencies, periods.
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 8; i++) rd_tbl[i] = 8'($urandom);
      clear_plan();
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 3) == 0) nack_plan['h94 + i] = int'($urandom_range(1, 2));
      if ($urandom_range(0, 2) == 0) nack_plan['h80] = int'($urandom_range(1, 3));
      rand_ready = 1'b1; lat_cfg = 0;
      sample_period = 24'($urandom_range(0, 5));
      run_burst("rand");
      chk("rand_err", 64'(err), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
